// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - writeback result select, load extension and register-write FIFO
module writeback_queue #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcW,
    input  logic [2:0]               LoadTypeW,
    input  logic [REG_AW-1:0]        RD_W,
    input  logic [XLEN-1:0]          ALUResultW,
    input  logic [XLEN-1:0]          ReadDataW,
    input  logic [XLEN-1:0]          PCPlus4W,
    input  logic [XLEN-1:0]          ImmExtW,
    output logic [XLEN-1:0]          ResultW,
    output logic [REG_AW-1:0]        RD_W_W,
    output logic                     RegWriteW_W,
    input  logic                     rf_ready,
    output logic                     load_misaligned,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]   r_data [DEPTH];
    logic [REG_AW-1:0] r_rd   [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_misaligned;

    logic [1:0]        w_offset;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_load;
    logic              w_ld_misaligned;
    logic              w_misaligned;
    logic [XLEN-1:0]   w_result;
    logic              w_empty;
    logic              w_full;
    logic              w_accept;
    logic              w_store;
    logic              w_pop;

    assign w_offset = ALUResultW[1:0];

    always_comb begin
        w_shifted       = ReadDataW >> {w_offset, 3'b000};
        w_load          = w_shifted;
        w_ld_misaligned = 1'b0;
        case (LoadTypeW)
            3'b000: w_load = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b100: w_load = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            3'b001: begin
                w_load          = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
                w_ld_misaligned = w_offset[0];
            end
            3'b101: begin
                w_load          = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
                w_ld_misaligned = w_offset[0];
            end
            // LW and the undefined encodings all behave as a word load
            default: begin
                w_load          = w_shifted;
                w_ld_misaligned = (w_offset != 2'b00);
            end
        endcase
    end

    always_comb begin
        w_misaligned = 1'b0;
        case (ResultSrcW)
            2'b00: w_result = ALUResultW;
            2'b01: begin
                w_misaligned = w_ld_misaligned;
                w_result     = w_ld_misaligned ? '0 : w_load;
            end
            2'b10: w_result = PCPlus4W;
            default: w_result = ImmExtW;
        endcase
    end

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_accept = in_valid && !w_full;
    // x0 and non-writing instructions complete the handshake without a slot
    assign w_store  = w_accept && RegWriteW && (RD_W != '0);
    assign w_pop    = !w_empty && rf_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_accept && w_misaligned;
            if (w_store) r_wptr <= r_wptr + PW'(1);
            if (w_pop)   r_rptr <= r_rptr + PW'(1);
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_data[r_wptr] <= w_result;
            r_rd[r_wptr]   <= RD_W;
        end
    end

    assign in_ready        = !w_full;
    assign RegWriteW_W     = !w_empty;
    assign ResultW         = w_empty ? '0 : r_data[r_rptr];
    assign RD_W_W          = w_empty ? '0 : r_rd[r_rptr];
    assign load_misaligned = r_misaligned;
    assign count           = r_count;

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, RegWriteW, RegWriteW_W, rf_ready, load_misaligned;
    logic [1:0]  ResultSrcW;
    logic [2:0]  LoadTypeW;
    logic [4:0]  RD_W, RD_W_W;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ImmExtW, ResultW;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;
    logic [4:0]  exp_rd[$];
    logic [31:0] exp_data[$];

    always #5 clk = ~clk;

    writeback_queue #(.XLEN(32), .REG_AW(5), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .LoadTypeW(LoadTypeW), .RD_W(RD_W),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .ImmExtW(ImmExtW),
        .ResultW(ResultW), .RD_W_W(RD_W_W), .RegWriteW_W(RegWriteW_W), .rf_ready(rf_ready),
        .load_misaligned(load_misaligned), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic regw, input logic [1:0] src, input logic [2:0] lt,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic push, input logic [31:0] exp);
        in_valid   = 1'b1;
        RegWriteW  = regw;
        ResultSrcW = src;
        LoadTypeW  = lt;
        RD_W       = rd;
        ALUResultW = alu;
        ReadDataW  = rdata;
        PCPlus4W   = pc;
        ImmExtW    = imm;
        if (push) begin
            exp_rd.push_back(rd);
            exp_data.push_back(exp);
        end
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && count != 2'd0; i++) cyc();
        chk("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; rf_ready = 1'b0;
        RegWriteW = 1'b0; ResultSrcW = 2'b00; LoadTypeW = 3'b010; RD_W = '0;
        ALUResultW = '0; ReadDataW = '0; PCPlus4W = '0; ImmExtW = '0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && !flush && RegWriteW_W && rf_ready) begin
                    if (exp_rd.size() == 0) begin
                        chk("unexpected_write_rd", 32'(RD_W_W), 32'hFFFF_FFFF);
                    end else begin
                        chk("sb_rd", 32'(RD_W_W), 32'(exp_rd.pop_front()));
                        chk("sb_data", ResultW, exp_data.pop_front());
                    end
                end
            end
        join_none

        cyc(); cyc();
        rst = 1'b0;
        chk("rst_wstrobe", 32'(RegWriteW_W), 32'd0);
        chk("rst_result", ResultW, 32'd0);
        chk("rst_rd", 32'(RD_W_W), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_misaligned", 32'(load_misaligned), 32'd0);

        rf_ready = 1'b1;
        send(1, 2'b00, 3'b010, 5'd5, 32'h1234, 0, 0, 0, 1, 32'h0000_1234);
        chk("lat_wstrobe", 32'(RegWriteW_W), 32'd1);
        chk("lat_rd", 32'(RD_W_W), 32'd5);
        chk("lat_result", ResultW, 32'h0000_1234);

        send(1, 2'b01, 3'b000, 5'd6,  32'h1003, 32'h80FF7F01, 0, 0, 1, 32'hFFFF_FF80);
        send(1, 2'b01, 3'b100, 5'd7,  32'h1003, 32'h80FF7F01, 0, 0, 1, 32'h0000_0080);
        send(1, 2'b01, 3'b001, 5'd8,  32'h1002, 32'h80FF7F01, 0, 0, 1, 32'hFFFF_80FF);
        send(1, 2'b01, 3'b101, 5'd9,  32'h1000, 32'h80FF7F01, 0, 0, 1, 32'h0000_7F01);
        send(1, 2'b01, 3'b010, 5'd10, 32'h1000, 32'h80FF7F01, 0, 0, 1, 32'h80FF_7F01);
        chk("lw_aligned_no_pulse", 32'(load_misaligned), 32'd0);

        send(1, 2'b01, 3'b010, 5'd11, 32'h1002, 32'h80FF7F01, 0, 0, 1, 32'h0);
        chk("lw_mis_pulse", 32'(load_misaligned), 32'd1);
        send(1, 2'b01, 3'b001, 5'd12, 32'h1001, 32'h80FF7F01, 0, 0, 1, 32'h0);
        chk("lh_mis_pulse", 32'(load_misaligned), 32'd1);
        cyc();
        chk("mis_pulse_end", 32'(load_misaligned), 32'd0);
        wait_drain();

        rf_ready = 1'b0;
        send(1, 2'b00, 3'b010, 5'd0, 32'h55, 0, 0, 0, 0, 0);
        send(0, 2'b00, 3'b010, 5'd7, 32'h66, 0, 0, 0, 0, 0);
        chk("x0_count", 32'(count), 32'd0);
        chk("x0_wstrobe", 32'(RegWriteW_W), 32'd0);

        send(1, 2'b00, 3'b010, 5'd1, 32'h11, 0, 0, 0, 1, 32'h11);
        send(1, 2'b00, 3'b010, 5'd2, 32'h22, 0, 0, 0, 1, 32'h22);
        chk("full_count", 32'(count), 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        send(1, 2'b00, 3'b010, 5'd3, 32'h33, 0, 0, 0, 0, 0);
        chk("full_hold_count", 32'(count), 32'd2);
        chk("full_hold_rd", 32'(RD_W_W), 32'd1);
        chk("full_hold_data", ResultW, 32'h11);
        rf_ready = 1'b1;
        cyc(); cyc();
        chk("bp_drained", 32'(count), 32'd0);

        for (int i = 0; i < 6; i++) begin
            send(1, 2'b00, 3'b010, 5'(20 + i), 32'h100 + 32'(i), 0, 0, 0, 1, 32'h100 + 32'(i));
            chk("wrap_count", 32'(count), 32'd1);
        end
        send(1, 2'b10, 3'b010, 5'd13, 32'h0, 0, 32'h104, 0, 1, 32'h0000_0104);
        send(1, 2'b11, 3'b010, 5'd14, 32'h0, 0, 0, 32'hABCDE000, 1, 32'hABCD_E000);
        wait_drain();

        rf_ready = 1'b0;
        send(1, 2'b00, 3'b010, 5'd15, 32'h15, 0, 0, 0, 1, 32'h15);
        send(1, 2'b00, 3'b010, 5'd16, 32'h16, 0, 0, 0, 1, 32'h16);
        chk("pre_flush_count", 32'(count), 32'd2);
        flush = 1'b1; rf_ready = 1'b1;
        send(1, 2'b00, 3'b010, 5'd17, 32'h17, 0, 0, 0, 0, 0);
        flush = 1'b0; rf_ready = 1'b0;
        exp_rd.delete(); exp_data.delete();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_wstrobe", 32'(RegWriteW_W), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);

        send(1, 2'b00, 3'b010, 5'd18, 32'h18, 0, 0, 0, 1, 32'h18);
        rst = 1'b1; rf_ready = 1'b1;
        send(1, 2'b00, 3'b010, 5'd19, 32'h19, 0, 0, 0, 0, 0);
        rst = 1'b0; rf_ready = 1'b0;
        exp_rd.delete(); exp_data.delete();
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_wstrobe", 32'(RegWriteW_W), 32'd0);
        chk("rst_mid_result", ResultW, 32'd0);

        rf_ready = 1'b1;
        send(1, 2'b00, 3'b010, 5'd31, 32'hCAFE, 0, 0, 0, 1, 32'hCAFE);
        wait_drain();
        cyc();
        chk("sb_empty", 32'(exp_rd.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
